// File: rtl/pwm_pkg.sv
// Shared PWM types: channel alignment mode, count direction and the per-channel compare rule.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Compare operands are zero-extended to this width by the caller.
  localparam int PWM_MAX_W = 32;

  // Down phase uses <= so a centre-aligned pulse is symmetric about counter 0.
  function automatic logic pwm_high(input logic [PWM_MAX_W-1:0] counter,
                                    input logic [PWM_MAX_W-1:0] duty,
                                    input logic                 dir);
    return (dir == DIR_DOWN) ? (counter <= duty) : (counter < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: tick is high for one clk every prescale+1 clk while enabled.
// Latency: combinational tick from the registered count; no backpressure.
module pwm_prescaler #(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] presc_q, presc_d;

  // >= rather than == so a live decrease of prescale cannot strand the count above it.
  always_comb begin
    tick    = enable && (presc_q >= prescale);
    presc_d = presc_q + PRESC_WIDTH'(1);
    if (!enable || tick) presc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared counter, edge/centre alignment and boundary-synchronous shadow update.
// Latency: outputs registered one clk after the counter; no backpressure (config inputs are always accepted).
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [PRESC_WIDTH-1:0]    prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic                      center_mode,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      update_done
);

  logic                      tick;
  logic                      bnd;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      dir_q, dir_d;
  logic                      pend_q, pend_d;
  logic [WIDTH-1:0]          act_per_q, act_per_d, sh_per_q, sh_per_d;
  pwm_mode_e                 act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
  logic [CHANNELS*WIDTH-1:0] act_duty_q, act_duty_d, sh_duty_q, sh_duty_d;
  logic                      wrap_q, wrap_d, upd_q, upd_d;
  logic [CHANNELS-1:0]       pwm_hi, pwm_q, pwm_d;
  logic                      ps_q, ud_q, ud_d;

  pwm_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    act_per_d  = act_per_q;
    act_mode_d = act_mode_q;
    act_duty_d = act_duty_q;
    sh_per_d   = sh_per_q;
    sh_mode_d  = sh_mode_q;
    sh_duty_d  = sh_duty_q;
    bnd        = 1'b0;

    if (!enable) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (act_per_q == '0) begin
        cnt_d = '0;
        bnd   = 1'b1;
      end else if (act_mode_q == PWM_EDGE) begin
        if (cnt_q == act_per_q) begin
          cnt_d = '0;
          bnd   = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else if (dir_q == DIR_UP) begin
        // Up phase ends at P-1; the next count (P) is the first of the down phase.
        cnt_d = cnt_q + WIDTH'(1);
        if (cnt_q == act_per_q - WIDTH'(1)) dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
        if (cnt_q == WIDTH'(1)) begin
          dir_d = DIR_UP;
          bnd   = 1'b1;
        end
      end
    end

    // Boundary consumes the shadow as it stood before any load on this same edge.
    if (bnd && pend_q) begin
      act_per_d  = sh_per_q;
      act_mode_d = sh_mode_q;
      act_duty_d = sh_duty_q;
      dir_d      = DIR_UP;
      pend_d     = 1'b0;
    end

    if (load) begin
      sh_per_d  = period;
      sh_mode_d = pwm_mode_e'(center_mode);
      sh_duty_d = duty;
      if (enable) begin
        pend_d = 1'b1;
      end else begin
        act_per_d  = period;
        act_mode_d = pwm_mode_e'(center_mode);
        act_duty_d = duty;
        pend_d     = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign pwm_hi[i] = pwm_high(PWM_MAX_W'(cnt_q), PWM_MAX_W'(act_duty_q[i*WIDTH +: WIDTH]), dir_q);
  end

  assign pwm_d  = enable ? pwm_hi : '0;
  assign wrap_d = bnd;
  assign upd_d  = bnd && pend_q;
  assign ud_d   = upd_q || (load && !enable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      pend_q     <= 1'b0;
      act_per_q  <= '1;
      act_mode_q <= PWM_EDGE;
      act_duty_q <= '0;
      sh_per_q   <= '1;
      sh_mode_q  <= PWM_EDGE;
      sh_duty_q  <= '0;
      wrap_q     <= 1'b0;
      upd_q      <= 1'b0;
      pwm_q      <= '0;
      ps_q       <= 1'b0;
      ud_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      act_per_q  <= act_per_d;
      act_mode_q <= act_mode_d;
      act_duty_q <= act_duty_d;
      sh_per_q   <= sh_per_d;
      sh_mode_q  <= sh_mode_d;
      sh_duty_q  <= sh_duty_d;
      wrap_q     <= wrap_d;
      upd_q      <= upd_d;
      pwm_q      <= pwm_d;
      ps_q       <= wrap_q;
      ud_q       <= ud_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign update_done  = ud_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed plus randomized bench for pwm_multi against a position-within-period reference model.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic [PW-1:0]   prescale = '0;
  logic [W-1:0]    period = '0;
  logic            center_mode = 1'b0;
  logic [CH*W-1:0] duty = '0;
  logic            load = 1'b0;
  logic [CH-1:0]   pwm_out;
  logic            period_start;
  logic            update_done;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESC_WIDTH(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .prescale     (prescale),
    .period       (period),
    .center_mode  (center_mode),
    .duty         (duty),
    .load         (load),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .update_done  (update_done)
  );

  always #5 clk = ~clk;

  // Model: pos is the tick index inside the current period (length P+1 edge, 2P centre).
  int            m_presc, m_pos, m_P, m_sP;
  bit            m_mode, m_smode, m_pend, m_wrap, m_upd;
  int            m_duty[CH];
  int            m_sduty[CH];
  logic [CH-1:0] e_pwm;
  logic          e_ps, e_ud;
  int            vectors = 0;
  int            miscompares = 0;
  string         tag;

  function automatic bit ch_high(int pos, int p, bit mode, int d);
    if (!mode) return pos < d;
    if (p == 0) return d != 0;
    return (pos < d) || (pos >= 2*p - d);
  endfunction

  task automatic model_reset();
    m_presc = 0; m_pos = 0; m_P = 255; m_sP = 255;
    m_mode = 0; m_smode = 0; m_pend = 0; m_wrap = 0; m_upd = 0;
    for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_sduty[i] = 0; end
    e_pwm = '0; e_ps = 1'b0; e_ud = 1'b0;
  endtask

  // Called just after a posedge with the inputs that were sampled on it.
  task automatic model_edge();
    int len;
    bit tk, bnd;
    for (int i = 0; i < CH; i++) e_pwm[i] = enable && ch_high(m_pos, m_P, m_mode, m_duty[i]);
    e_ps = m_wrap;
    e_ud = m_upd || (load && !enable);
    tk   = enable && (m_presc == int'(prescale));
    len  = m_mode ? ((m_P == 0) ? 1 : 2*m_P) : m_P + 1;
    bnd  = 0;
    if (!enable) begin
      m_presc = 0; m_pos = 0;
    end else if (tk) begin
      m_presc = 0;
      m_pos = (m_pos + 1) % len;
      bnd = (m_pos == 0);
    end else begin
      m_presc++;
    end
    m_wrap = bnd;
    m_upd  = bnd && m_pend;
    if (m_upd) begin
      m_P = m_sP; m_mode = m_smode; m_pend = 0;
      for (int i = 0; i < CH; i++) m_duty[i] = m_sduty[i];
    end
    if (load) begin
      m_sP = int'(period); m_smode = center_mode;
      for (int i = 0; i < CH; i++) m_sduty[i] = int'(duty[i*W +: W]);
      if (enable) m_pend = 1;
      else begin
        m_P = m_sP; m_mode = m_smode; m_pend = 0;
        for (int i = 0; i < CH; i++) m_duty[i] = m_sduty[i];
      end
    end
  endtask

  task automatic check();
    vectors++;
    assert ({pwm_out, period_start, update_done} === {e_pwm, e_ps, e_ud})
    else begin
      miscompares++;
      $error("FAIL %s t=%0t pwm=%b ps=%b ud=%b expected pwm=%b ps=%b ud=%b",
             tag, $time, pwm_out, period_start, update_done, e_pwm, e_ps, e_ud);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check();
      load = 1'b0;
    end
  endtask

  task automatic do_load(input int p, input bit m, input int d0, input int d1, input int d2, input int d3);
    period      = W'(p);
    center_mode = m;
    duty        = {W'(d3), W'(d2), W'(d1), W'(d0)};
    load        = 1'b1;
    run(1);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tag = "reset"; check();
    rst = 1'b0;

    tag = "disabled_load";
    do_load(9, 0, 3, 10, 0, 7);
    tag = "edge_p9";
    enable = 1'b1;
    run(32);

    tag = "midload";
    do_load(9, 0, 5, 0, 10, 2);
    run(25);

    tag = "bndload";
    for (int k = 0; k < 40 && !(m_pos == m_P && m_presc == int'(prescale)); k++) run(1);
    do_load(9, 0, 8, 1, 4, 9);
    run(25);

    tag = "centre";
    enable = 1'b0;
    prescale = 8'd1;
    do_load(4, 1, 2, 4, 0, 1);
    enable = 1'b1;
    run(40);

    tag = "centre_p0_p1";
    do_load(0, 1, 0, 1, 3, 0);
    run(20);
    do_load(1, 1, 1, 4, 0, 2);
    run(20);

    tag = "async_rst";
    #2 rst = 1'b1;
    #1;
    model_reset();
    check();
    rst = 1'b0;
    tag = "post_rst";
    run(20);

    tag = "random";
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        enable = ~enable;
        if (!enable) prescale = PW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 14) == 0) begin
        period      = W'($urandom_range(0, 12));
        center_mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < CH; i++) duty[i*W +: W] = W'($urandom_range(0, 14));
        load = 1'b1;
      end
      run(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
